// File: rtl/ibert_exdes_quad_ctrl.sv
// 4-lane GT quad IBERT example controller: PLL/TX/RX reset sequencing, per-lane PRBS
// generation and self-synchronizing checking. Define IBERT_ERR_INJECT_EN to add lane-0 error injection.
module ibert_exdes_quad_ctrl #(
  parameter int unsigned PLL_LOCK_CYCLES  = 256,
  parameter int unsigned RESET_CYCLES     = 64,
  parameter int unsigned LINK_GOOD_CYCLES = 128,
  parameter int unsigned USRCLK_DIV       = 1
) (
  input  logic        apb3clk_quad,
  input  logic        apb3_presetn,
  input  logic        gt_reset_ip0,
  input  logic [3:0]  rate_sel_ip0,
  input  logic        gpio_enable_ip0,
  input  logic [3:0]  GT_Serial_grx_p,
  input  logic [3:0]  GT_Serial_grx_n,
  output logic [3:0]  GT_Serial_gtx_p,
  output logic [3:0]  GT_Serial_gtx_n,
  output logic        lcpll_lock_ip0,
  output logic        rpll_lock_ip0,
  output logic        tx_resetdone_out_ip0,
  output logic        rx_resetdone_out_ip0,
  output logic        txusrclk_ip0,
  output logic        rxusrclk_ip0,
  output logic        link_status_ip0,
`ifdef IBERT_ERR_INJECT_EN
  input  logic        err_inject_ip0,
`endif
  output logic [15:0] prbs_err_cnt_ip0
);

  typedef enum logic [2:0] {PLL_WAIT, TX_RST, RX_RST, RX_ALIGN, CHECK, LINK_UP} state_t;

  state_t      state;
  logic [31:0] cnt;
  logic        lock, tx_done, rx_done, link;
  logic [15:0] err_cnt;
  logic [3:0]  rate_q;
  logic [1:0]  poly;
  logic        rate_chg;

  logic [30:0] lfsr [4];
  logic [30:0] hist [4];
  logic [3:0]  tx_bit, tx_fb, rx_p, rx_n, lane_err;
  logic [2:0]  err_lanes;
  logic        any_err;
  logic [16:0] err_sum;
  logic [31:0] txdiv, rxdiv;
  logic        txclk, rxclk;

  function automatic logic tap(input logic [30:0] s, input logic [1:0] p);
    unique case (p)
      2'd0:    tap = s[6] ^ s[5];
      2'd1:    tap = s[14] ^ s[13];
      default: tap = s[30] ^ s[27];
    endcase
  endfunction

  assign poly     = (rate_q == 4'd0) ? 2'd0 : (rate_q == 4'd1) ? 2'd1 : 2'd2;
  assign rate_chg = lock && (rate_sel_ip0 != rate_q);

`ifdef IBERT_ERR_INJECT_EN
  assign GT_Serial_gtx_p = tx_bit ^ {3'b000, err_inject_ip0 & tx_done};
`else
  assign GT_Serial_gtx_p = tx_bit;
`endif
  assign GT_Serial_gtx_n = ~GT_Serial_gtx_p;

  // Checker predicts each bit from its own received history, so it locks to any phase of the stream.
  always_comb begin
    err_lanes = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      tx_fb[i]    = tap(lfsr[i], poly);
      lane_err[i] = (rx_p[i] == rx_n[i]) || (rx_p[i] != tap(hist[i], poly));
      err_lanes   = err_lanes + {2'b00, lane_err[i]};
    end
    any_err = (|lane_err) && (state == CHECK || state == LINK_UP);
    err_sum = {1'b0, err_cnt} + {14'b0, err_lanes};
  end

  always_ff @(posedge apb3clk_quad or negedge apb3_presetn) begin
    if (!apb3_presetn) rate_q <= '0;
    else               rate_q <= rate_sel_ip0;
  end

  always_ff @(posedge apb3clk_quad or negedge apb3_presetn) begin
    if (!apb3_presetn) begin
      state <= PLL_WAIT; cnt <= '0; lock <= 1'b0; tx_done <= 1'b0;
      rx_done <= 1'b0; link <= 1'b0; err_cnt <= '0;
    end else if (gt_reset_ip0) begin
      state <= PLL_WAIT; cnt <= '0; lock <= 1'b0; tx_done <= 1'b0;
      rx_done <= 1'b0; link <= 1'b0; err_cnt <= '0;
    end else if (rate_chg) begin
      state <= TX_RST; cnt <= '0; tx_done <= 1'b0; rx_done <= 1'b0; link <= 1'b0;
    end else begin
      if (any_err) err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      unique case (state)
        PLL_WAIT: if (cnt == PLL_LOCK_CYCLES - 1) begin
                    lock <= 1'b1; state <= TX_RST; cnt <= '0;
                  end else cnt <= cnt + 1;
        TX_RST:   if (cnt == RESET_CYCLES - 1) begin
                    tx_done <= 1'b1; state <= RX_RST; cnt <= '0;
                  end else cnt <= cnt + 1;
        RX_RST:   if (cnt == RESET_CYCLES - 1) begin
                    rx_done <= 1'b1; state <= RX_ALIGN; cnt <= '0;
                  end else cnt <= cnt + 1;
        RX_ALIGN: if (cnt == 32'd30) begin
                    state <= CHECK; cnt <= '0;
                  end else cnt <= cnt + 1;
        CHECK:    if (any_err) begin
                    state <= RX_ALIGN; cnt <= '0;
                  end else if (cnt == LINK_GOOD_CYCLES - 1) begin
                    link <= 1'b1; state <= LINK_UP; cnt <= '0;
                  end else cnt <= cnt + 1;
        LINK_UP:  if (any_err) begin
                    link <= 1'b0; state <= RX_ALIGN; cnt <= '0;
                  end
        default:  state <= PLL_WAIT;
      endcase
    end
  end

  always_ff @(posedge apb3clk_quad or negedge apb3_presetn) begin
    if (!apb3_presetn) begin
      for (int unsigned i = 0; i < 4; i++) begin
        lfsr[i] <= '1; hist[i] <= '0;
      end
      tx_bit <= '0; rx_p <= '0; rx_n <= '1;
      txdiv <= '0; rxdiv <= '0; txclk <= 1'b0; rxclk <= 1'b0;
    end else if (gt_reset_ip0) begin
      for (int unsigned i = 0; i < 4; i++) begin
        lfsr[i] <= '1; hist[i] <= '0;
      end
      tx_bit <= '0; rx_p <= '0; rx_n <= '1;
      txdiv <= '0; rxdiv <= '0; txclk <= 1'b0; rxclk <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (tx_done) begin
          lfsr[i]   <= {lfsr[i][29:0], tx_fb[i]};
          tx_bit[i] <= tx_fb[i];
        end else begin
          lfsr[i]   <= '1;
          tx_bit[i] <= 1'b0;
        end
        hist[i] <= {hist[i][29:0], rx_p[i]};
      end
      rx_p <= gpio_enable_ip0 ? GT_Serial_gtx_p : GT_Serial_grx_p;
      rx_n <= gpio_enable_ip0 ? GT_Serial_gtx_n : GT_Serial_grx_n;
      if (!lock) begin
        txdiv <= '0; txclk <= 1'b0;
      end else if (txdiv == USRCLK_DIV - 1) begin
        txdiv <= '0; txclk <= ~txclk;
      end else txdiv <= txdiv + 1;
      if (!rx_done) begin
        rxdiv <= '0; rxclk <= 1'b0;
      end else if (rxdiv == USRCLK_DIV - 1) begin
        rxdiv <= '0; rxclk <= ~rxclk;
      end else rxdiv <= rxdiv + 1;
    end
  end

  assign lcpll_lock_ip0       = lock;
  assign rpll_lock_ip0        = lock;
  assign tx_resetdone_out_ip0 = tx_done;
  assign rx_resetdone_out_ip0 = rx_done;
  assign link_status_ip0      = link;
  assign txusrclk_ip0         = txclk;
  assign rxusrclk_ip0         = rxclk;
  assign prbs_err_cnt_ip0     = err_cnt;

endmodule

// File: tb/tb_ibert_exdes_quad_ctrl.sv
// Self-checking bench for ibert_exdes_quad_ctrl in TX->RX loopback.
module tb_ibert_exdes_quad_ctrl;

  logic        clk = 1'b0;
  logic        presetn = 1'b0;
  logic        gt_reset = 1'b1;
  logic [3:0]  rate_sel = 4'd0;
  logic        gpio = 1'b0;
  logic        rx_hold = 1'b0;
  logic [3:0]  force_mask = 4'b0000;
  logic [3:0]  grx_p, grx_n, gtx_p, gtx_n;
  logic        lc_lock, r_lock, tx_done, rx_done, txusr, rxusr, link;
  logic [15:0] err_cnt;
`ifdef IBERT_ERR_INJECT_EN
  logic        err_inject = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;
  logic exp_q [$];

  always #5 clk = ~clk;

  assign grx_p = rx_hold ? 4'b0000 : (gtx_p & ~force_mask);
  assign grx_n = rx_hold ? 4'b0000 : (gtx_n & ~force_mask);

  ibert_exdes_quad_ctrl dut (
    .apb3clk_quad(clk), .apb3_presetn(presetn), .gt_reset_ip0(gt_reset),
    .rate_sel_ip0(rate_sel), .gpio_enable_ip0(gpio),
    .GT_Serial_grx_p(grx_p), .GT_Serial_grx_n(grx_n),
    .GT_Serial_gtx_p(gtx_p), .GT_Serial_gtx_n(gtx_n),
    .lcpll_lock_ip0(lc_lock), .rpll_lock_ip0(r_lock),
    .tx_resetdone_out_ip0(tx_done), .rx_resetdone_out_ip0(rx_done),
    .txusrclk_ip0(txusr), .rxusrclk_ip0(rxusr), .link_status_ip0(link),
`ifdef IBERT_ERR_INJECT_EN
    .err_inject_ip0(err_inject),
`endif
    .prbs_err_cnt_ip0(err_cnt)
  );

  // Expected PRBS bit stream from an all-ones seed, queued when TX comes out of reset.
  task automatic push_prbs(input int nbits, input logic [3:0] rate);
    logic [30:0] m;
    logic nb;
    m = '1;
    for (int k = 0; k < nbits; k++) begin
      if (rate == 4'd0)      nb = m[6] ^ m[5];
      else if (rate == 4'd1) nb = m[14] ^ m[13];
      else                   nb = m[30] ^ m[27];
      m = {m[29:0], nb};
      exp_q.push_back(nb);
    end
  endtask

  task automatic count_until_link(input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (link === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({lc_lock, r_lock, tx_done, rx_done, txusr, rxusr, link} !== 7'b0 || err_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_status: got %b err=%0d, want 0000000 err=0",
               {lc_lock, r_lock, tx_done, rx_done, txusr, rxusr, link}, err_cnt);
    end
    compared++;
    if (gtx_p !== 4'b0000 || gtx_n !== 4'b1111) begin
      mismatched++;
      $display("FAIL reset_gtx: got p=%b n=%b, want p=0000 n=1111", gtx_p, gtx_n);
    end
    @(negedge clk) presetn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    compared++;
    if (lc_lock !== 1'b0 || tx_done !== 1'b0) begin
      mismatched++;
      $display("FAIL gt_reset_hold: got lock=%b txdone=%b, want 0 0", lc_lock, tx_done);
    end
  endtask

  task automatic test_bringup;
    int lock_at = -1, rlock_at = -1, tx_at = -1, rx_at = -1, link_at = -1;
    logic e;
    exp_q.delete();
    @(negedge clk) gt_reset = 1'b0;
    for (int cyc = 1; cyc <= 560; cyc++) begin
      @(posedge clk); #1;
      if (lc_lock === 1'b1 && lock_at < 0) lock_at = cyc;
      if (r_lock === 1'b1 && rlock_at < 0) rlock_at = cyc;
      if (rx_done === 1'b1 && rx_at < 0) rx_at = cyc;
      if (link === 1'b1 && link_at < 0) link_at = cyc;
      if (tx_done === 1'b1 && tx_at < 0) begin
        tx_at = cyc;
        push_prbs(40, rate_sel);
        compared++;
        if (gtx_p !== 4'b0000) begin
          mismatched++;
          $display("FAIL tx_idle_bits: cycle %0d got %b, want 0000", cyc, gtx_p);
        end
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared++;
        if (gtx_p !== {4{e}} || gtx_n !== ~{4{e}}) begin
          mismatched++;
          $display("FAIL tx_prbs: cycle %0d got p=%b n=%b, want p=%b", cyc, gtx_p, gtx_n, {4{e}});
        end
      end
      if (cyc >= 250 && cyc <= 262) begin
        compared++;
        if (txusr !== ((cyc > 256) ? logic'((cyc - 256) % 2) : 1'b0)) begin
          mismatched++;
          $display("FAIL txusrclk: cycle %0d got %b", cyc, txusr);
        end
      end
      if (cyc >= 378 && cyc <= 390) begin
        compared++;
        if (rxusr !== ((cyc > 384) ? logic'((cyc - 384) % 2) : 1'b0)) begin
          mismatched++;
          $display("FAIL rxusrclk: cycle %0d got %b", cyc, rxusr);
        end
      end
    end
    compared++;
    if (lock_at != 256 || rlock_at != 256) begin
      mismatched++;
      $display("FAIL lock_time: got lc=%0d r=%0d, want 256", lock_at, rlock_at);
    end
    compared++;
    if (tx_at != 320) begin
      mismatched++;
      $display("FAIL txdone_time: got %0d, want 320", tx_at);
    end
    compared++;
    if (rx_at != 384) begin
      mismatched++;
      $display("FAIL rxdone_time: got %0d, want 384", rx_at);
    end
    compared++;
    if (link_at != 543) begin
      mismatched++;
      $display("FAIL link_time: got %0d, want 543", link_at);
    end
    compared++;
    if (err_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL bringup_errs: got %0d, want 0", err_cnt);
    end
  endtask

  task automatic test_lane_error;
    int n;
    @(negedge clk) force_mask = 4'b0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    compared++;
    if (link !== 1'b0) begin
      mismatched++;
      $display("FAIL lane_err_drop: got link=%b, want 0", link);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) force_mask = 4'b0000;
    count_until_link(300, n);
    // first bad sample at edge 1; link returns 31 align + 128 good clocks after detection
    compared++;
    if (n != 161 - 5) begin
      mismatched++;
      $display("FAIL lane_err_recover: got %0d edges after release, want 156", n);
    end
    compared++;
    if (err_cnt !== 16'd1) begin
      mismatched++;
      $display("FAIL lane_err_count: got %0d, want 1", err_cnt);
    end
  endtask

  task automatic test_rate_change;
    int n;
    @(negedge clk) rate_sel = 4'd1;
    @(posedge clk); #1;
    compared++;
    if ({tx_done, rx_done, link} !== 3'b000 || {lc_lock, r_lock} !== 2'b11) begin
      mismatched++;
      $display("FAIL rate_drop: got tx/rx/link=%b locks=%b, want 000 11",
               {tx_done, rx_done, link}, {lc_lock, r_lock});
    end
    count_until_link(400, n);
    compared++;
    if (n != 287) begin
      mismatched++;
      $display("FAIL rate_relock: got %0d edges, want 287", n);
    end
    compared++;
    if (err_cnt !== 16'd1) begin
      mismatched++;
      $display("FAIL rate_errs: got %0d, want 1", err_cnt);
    end
  endtask

  task automatic test_gt_reset_midlink;
    int n;
    @(negedge clk) gt_reset = 1'b1;
    @(posedge clk); #1;
    compared++;
    if ({lc_lock, r_lock, tx_done, rx_done, txusr, rxusr, link} !== 7'b0 || err_cnt !== 16'd0 ||
        gtx_p !== 4'b0000 || gtx_n !== 4'b1111) begin
      mismatched++;
      $display("FAIL gtrst_clear: got %b err=%0d p=%b, want 0000000 err=0 p=0000",
               {lc_lock, r_lock, tx_done, rx_done, txusr, rxusr, link}, err_cnt, gtx_p);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) gt_reset = 1'b0;
    count_until_link(700, n);
    compared++;
    if (n != 543) begin
      mismatched++;
      $display("FAIL gtrst_relink: got %0d, want 543", n);
    end
  endtask

  task automatic test_gpio_loopback;
    int n;
    @(negedge clk) begin
      gt_reset = 1'b1; gpio = 1'b1; rx_hold = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk) gt_reset = 1'b0;
    count_until_link(700, n);
    compared++;
    if (n != 543) begin
      mismatched++;
      $display("FAIL gpio_link: got %0d, want 543", n);
    end
    compared++;
    if (err_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL gpio_errs: got %0d, want 0", err_cnt);
    end
  endtask

`ifdef IBERT_ERR_INJECT_EN
  task automatic test_err_inject;
    int n;
    @(negedge clk) err_inject = 1'b1;
    @(negedge clk) err_inject = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (link !== 1'b0) begin
      mismatched++;
      $display("FAIL inject_drop: got link=%b, want 0", link);
    end
    count_until_link(300, n);
    compared++;
    if (n < 150 || n > 165) begin
      mismatched++;
      $display("FAIL inject_recover: got %0d, want about 159", n);
    end
    compared++;
    if (err_cnt < 16'd1 || err_cnt > 16'd3) begin
      mismatched++;
      $display("FAIL inject_count: got %0d, want 1..3", err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bringup();
    test_lane_error();
    test_rate_change();
    test_gt_reset_midlink();
    test_gpio_loopback();
`ifdef IBERT_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
